// File: rtl/game_pkg.sv
// Shared game definitions: button count, channel FSM encoding and small
// encode helpers used by the button front-end and the hit checker.
package game_pkg;

    localparam int N_BTN = 4;
    localparam int IDX_W = 2;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // Lowest set bit wins; returns 0 when nothing is set.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_BTN-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic multi_set(input logic [N_BTN-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < N_BTN; i++) begin
            if (v[i]) n++;
        end
        return (n >= 2);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, stability counter and debounce FSM.
// BUTTON_ACTIVE_LOW_EN inverts the raw pin ahead of the synchronizer.
module debounce_channel
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic press_nxt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic raw_in;
    logic sync_p0, sync_p1;
    logic [1:0] state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic level_nxt;

`ifdef BUTTON_ACTIVE_LOW_EN
    assign raw_in = ~btn_raw;
`else
    assign raw_in = btn_raw;
`endif

    // Stage p0/p1: metastability filter
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw_in;
            sync_p1 <= sync_p0;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level;
        press_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sync_p1) begin
                    state_nxt = ST_PRESS_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync_p1) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_MAX) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!sync_p1) begin
                    state_nxt = ST_RELEASE_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                // A return to 1 here is release bounce: back to held, no new pulse
                if (sync_p1) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_MAX) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level_nxt;
            press <= press_nxt;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Four-button front-end: debounced levels, single-cycle press pulses and a
// registered press summary. Optional macro: BUTTON_ACTIVE_LOW_EN (inverted pins).
module button_conditioner
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic             press_valid,
    output logic [IDX_W-1:0] press_idx,
    output logic             multi_press
);

    logic [N_BTN-1:0] press_nxt;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .btn_raw  (btn_raw[i]),
            .level    (btn_level[i]),
            .press    (btn_press[i]),
            .press_nxt(press_nxt[i])
        );
    end

    // Summary is built from the channels' next pulse so it lands with btn_press
    always_ff @(posedge clk) begin
        if (rst) begin
            press_valid <= 1'b0;
            press_idx   <= '0;
            multi_press <= 1'b0;
        end else begin
            press_valid <= |press_nxt;
            press_idx   <= lowest_set(press_nxt);
            multi_press <= multi_set(press_nxt);
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with a run-length reference model.
// Builds with or without BUTTON_ACTIVE_LOW_EN; stimulus is written as logical presses.
module tb_button_conditioner;

    localparam int DEB = 4;
`ifdef BUTTON_ACTIVE_LOW_EN
    localparam logic [3:0] POL = 4'hF;
`else
    localparam logic [3:0] POL = 4'h0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic       press_valid;
    logic [1:0] press_idx;
    logic       multi_press;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .press_valid(press_valid),
        .press_idx  (press_idx),
        .multi_press(multi_press)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: sync delay line plus, per channel, the length of the current run of
    // synchronized samples disagreeing with the accepted level.
    logic [3:0] m_s1, m_s2, m_lvl, m_press;
    int         m_run [4];

    typedef struct {
        logic       r;
        logic [3:0] mask;
        logic [3:0] press;
        logic [3:0] level;
        logic       valid;
        logic [1:0] idx;
        logic       multi;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [3:0] mask);
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0;
            for (int c = 0; c < 4; c++) m_run[c] = 0;
        end else begin
            m_press = '0;
            for (int c = 0; c < 4; c++) begin
                if (m_s2[c] != m_lvl[c]) m_run[c]++;
                else m_run[c] = 0;
                if (m_run[c] == DEB + 1) begin
                    m_lvl[c]   = ~m_lvl[c];
                    m_press[c] = m_lvl[c];
                    m_run[c]   = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = mask;
        end
    endtask

    task automatic compare_model();
        logic [1:0] e_idx;
        e_idx = 2'd0;
        for (int c = 3; c >= 0; c--) if (m_press[c]) e_idx = 2'(c);
        check("model_level", btn_level, m_lvl);
        check("model_press", btn_press, m_press);
        check("model_valid", {3'b0, press_valid}, {3'b0, (m_press != 0)});
        check("model_idx", {2'b0, press_idx}, {2'b0, e_idx});
        check("model_multi", {3'b0, multi_press}, {3'b0, ($countones(m_press) > 1)});
    endtask

    task automatic step(input logic r, input logic [3:0] mask);
        rst     = r;
        btn_raw = mask ^ POL;
        @(posedge clk);
        model_edge(r, mask);
        #1;
        compare_model();
    endtask

    initial begin
        int pulses, off, drop;
        logic [3:0] mask;
        logic       r;

        rst     = 1'b1;
        btn_raw = POL;

        tbl[0] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        for (int i = 1; i <= 6; i++) tbl[i] = '{1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[7] = '{1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[8] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0};
        for (int i = 9; i <= 14; i++) tbl[i] = '{1'b0, 4'b1011, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0};
        tbl[15] = '{1'b0, 4'b1011, 4'b1010, 4'b1011, 1'b1, 2'd1, 1'b1};
        tbl[16] = '{1'b0, 4'b1011, 4'b0000, 4'b1011, 1'b0, 2'd0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].r, tbl[i].mask);
            check("tbl_press", btn_press, tbl[i].press);
            check("tbl_level", btn_level, tbl[i].level);
            check("tbl_valid", {3'b0, press_valid}, {3'b0, tbl[i].valid});
            check("tbl_idx", {2'b0, press_idx}, {2'b0, tbl[i].idx});
            check("tbl_multi", {3'b0, multi_press}, {3'b0, tbl[i].multi});
        end

        // Bounce on channel 2, then a clean hold: one pulse 6 edges after final rise
        step(1'b1, 4'b0000);
        pulses = 0;
        off    = -1;
        step(1'b0, 4'b0100); pulses += int'(btn_press[2]);
        step(1'b0, 4'b0000); pulses += int'(btn_press[2]);
        step(1'b0, 4'b0100); pulses += int'(btn_press[2]);
        step(1'b0, 4'b0000); pulses += int'(btn_press[2]);
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 4'b0100);
            if (btn_press[2]) begin
                pulses++;
                off = k;
                check("toggle_idx", {2'b0, press_idx}, 4'd2);
            end
        end
        check("toggle_pulses", 4'(pulses), 4'd1);
        check("toggle_offset", 4'(off), 4'd6);

        // Long hold on channel 1 with a release glitch
        step(1'b1, 4'b0000);
        pulses = 0;
        drop   = -1;
        for (int k = 0; k < 100; k++) begin
            step(1'b0, 4'b0010);
            pulses += int'(btn_press[1]);
        end
        for (int k = 0; k < 3; k++) begin step(1'b0, 4'b0000); pulses += int'(btn_press[1]); end
        for (int k = 0; k < 2; k++) begin step(1'b0, 4'b0010); pulses += int'(btn_press[1]); end
        check("glitch_level_held", btn_level, 4'b0010);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 4'b0000);
            pulses += int'(btn_press[1]);
            if (drop < 0 && !btn_level[1]) drop = k;
        end
        check("glitch_pulses", 4'(pulses), 4'd1);
        check("glitch_drop_offset", 4'(drop), 4'd6);

        // Reset while channel 0 sits at cnt=3 in PRESS_WAIT
        step(1'b1, 4'b0000);
        pulses = 0;
        off    = -1;
        for (int k = 0; k < 5; k++) begin step(1'b0, 4'b0001); pulses += int'(btn_press[0]); end
        step(1'b1, 4'b0001);
        check("rst_mid_press", btn_press, 4'b0000);
        check("rst_mid_level", btn_level, 4'b0000);
        check("rst_mid_valid", {3'b0, press_valid}, 4'd0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 4'b0001);
            if (btn_press[0]) begin pulses++; off = k; end
        end
        check("rst_pulses", 4'(pulses), 4'd1);
        check("rst_offset", 4'(off), 4'd6);

        // Randomized: alternating quiet and bouncy phases, rare resets
        step(1'b1, 4'b0000);
        mask = 4'b0000;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (((k / 40) % 2) == 1) begin
                    if ($urandom_range(3) == 0) mask[c] = ~mask[c];
                end else begin
                    if ($urandom_range(31) == 0) mask[c] = ~mask[c];
                end
            end
            r = ($urandom_range(499) == 0);
            step(r, mask);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end for the game's four player buttons. Runs between the raw board push-buttons and the hit-checking logic.
- Synchronizes each raw input and debounces it.
- Emits one clean single-cycle press pulse per physical press, plus an encoded "which button" summary for the hit checker.
- Keeps bounce and metastability out of the game FSM's scoring path.

Parameters:
- N_BTN, 4, number of button channels (fixed at 4 for the game; press_idx width derived as 2).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a level change (1 ms at 50 MHz).
- CNT_W, 16, stability counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  4  asynchronous raw buttons; bit i = button(i+1).
- btn_level  out  4  debounced level, 1 = held.
- btn_press  out  4  one-cycle pulse on accepted press, per channel.
- press_valid  out  1  high in any cycle where btn_press != 0.
- press_idx  out  2  index of the lowest-numbered pulsing channel; 0 when press_valid=0.
- multi_press  out  1  high when more than one btn_press bit is set in the same cycle.

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. All outputs, synchronizer flops, counters and channel FSMs go to 0/IDLE on the first clk edge with rst=1. A mid-debounce reset abandons the count and takes no action on the pending press.
- Synchronizer: 2-flop per channel, reset to 0. The first stage's input is btn_raw[i], or its inverse when the optional feature is enabled.
- Per-channel FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: when the sync output is 1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT: when the sync output is 1, cnt++. When cnt reaches DEBOUNCE_CYCLES, go to PRESSED and assert btn_press[i] for exactly that one cycle. When the sync output is 0, return to IDLE with cnt=0 (bounce rejected).
  - PRESSED: btn_level[i]=1. When the sync output is 0, go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT: when the sync output is 0, cnt++. When cnt reaches DEBOUNCE_CYCLES, go to IDLE with btn_level[i]=0. When the sync output is 1, return to PRESSED (release bounce rejected; no new pulse).
- Latency: btn_press[i] and the btn_level[i] rise are registered. They appear 2+DEBOUNCE_CYCLES clk edges after the first edge that samples btn_raw high, provided the input stays stable.
- Holding a button never re-pulses. A new pulse requires a full debounced release first.
- Summary outputs are registered in the same cycle as btn_press.
  - press_idx is a priority encode, lowest index wins.
  - multi_press = popcount(btn_press) >= 2.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES and never wraps.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses.

Optional Feature:
- Macro: BUTTON_ACTIVE_LOW_EN.
- Defined: btn_raw is inverted before the synchronizer. Use this for board KEY pins that read 0 when pressed; the synchronizer then resets to the released value, 0 after inversion.
- Undefined: btn_raw is treated as active-high with no inversion.
- All other behaviour is identical in both cases.

Decomposition:
- Shared package (game_pkg): channel FSM state encoding (2-bit IDLE/PRESS_WAIT/PRESSED/RELEASE_WAIT) and the N_BTN constant, reused by the hit checker.
- Sub-module debounce_channel: one instance per button. It contains the synchronizer, counter and FSM, and outputs level/press.
- The top level instantiates 4 channels plus the registered priority encoder and popcount.

Test Plan:
- DEBOUNCE_CYCLES=4; raise btn_raw[0] cleanly at edge 0 -> btn_press=4'b0001 for exactly one cycle at edge 6, press_valid=1, press_idx=0, btn_level[0]=1 from edge 6.
- btn_raw[2] toggles 1,0,1,0 on successive cycles, then holds 1 -> no pulse during the toggling; one pulse with press_idx=2 six edges after the final rise.
- Hold btn_raw[1] for 100 cycles, release with a 2-cycle glitch back to 1 mid-release-wait, then stay 0 -> exactly one press pulse total; btn_level[1] drops 4 stable cycles after the last 0 sync sample.
- Raise btn_raw[1] and btn_raw[3] on the same edge -> btn_press=4'b1010 in one cycle, press_idx=1, multi_press=1.
- Assert rst for one cycle at cnt=3 in PRESS_WAIT -> no pulse, all outputs 0 the next cycle; the held button then pulses 6 edges after rst deasserts.
- With BUTTON_ACTIVE_LOW_EN: btn_raw idles at 4'b1111 -> no pulses; drive bit 0 low -> btn_press=4'b0001 after 6 edges.
